// File: rtl/weight_fetch_ctrl.sv
// rtl/weight_fetch_ctrl.sv - sequential weight fetch from one BRAM into a valid/ready MAC stream
//
// Purpose: on START, reads addresses 0..DEPTH-1 from a weight BRAM whose output
// updates on the falling edge, buffers the words in a 2-entry FIFO and streams
// them to the MAC, tolerating W_READY backpressure without loss.
// Optional feature macro: WEIGHT_LOAD_EN (adds a LOAD state that writes DEPTH
// words into the BRAM from the LD_* beat interface).
//
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   START             begin a fetch (ignored unless idle)
//   BUSY, DONE        fetch in progress / 1-cycle completion pulse
//   BRAM_ADDR/EN/WE/DI/DO  BRAM read (and optional write) port
//   W_DATA/VALID/READY/LAST  weight stream to the MAC
//   LD_START/VALID/DATA, LD_DONE  weight load interface (WEIGHT_LOAD_EN only)
module weight_fetch_ctrl #(
  parameter int DEPTH  = 28,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  output logic              BUSY,
  output logic              DONE,
  output logic [ADDR_W-1:0] BRAM_ADDR,
  output logic              BRAM_EN,
  output logic              BRAM_WE,
  output logic [DATA_W-1:0] BRAM_DI,
  input  logic [DATA_W-1:0] BRAM_DO,
  output logic [DATA_W-1:0] W_DATA,
  output logic              W_VALID,
  input  logic              W_READY,
  output logic              W_LAST
`ifdef WEIGHT_LOAD_EN
  ,
  input  logic              LD_START,
  input  logic              LD_VALID,
  input  logic [DATA_W-1:0] LD_DATA,
  output logic              LD_DONE
`endif
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE_ST
`ifdef WEIGHT_LOAD_EN
    ,
    S_LOAD
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  issue_q, issue_d;
  logic [CNT_W-1:0]  accept_q, accept_d;
  logic [DATA_W-1:0] buf0_q, buf1_q;
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q, count_d;
  logic              rd_en, push, pop, w_valid, w_last;
  logic [DATA_W-1:0] head;

`ifdef WEIGHT_LOAD_EN
  logic [CNT_W-1:0]  ld_q, ld_d;
  logic              ld_done_q, ld_done_d;
  logic              ld_wr;
`endif

  // The BRAM delivers data on the falling edge of the issue cycle, so the word
  // is captured on the very next rising edge; a read is only in flight within
  // its own cycle. Issuing only while the FIFO has a free slot guarantees the
  // captured word always fits.
  assign rd_en   = (state_q == S_RUN) && (issue_q < DEPTH_C) && (count_q != 2'd2);
  assign push    = rd_en;
  assign w_valid = (count_q != 2'd0);
  assign pop     = w_valid && W_READY;
  assign head    = rd_ptr_q ? buf1_q : buf0_q;
  assign w_last  = w_valid && (accept_q == LAST_IDX);

  always_comb begin
    state_d  = state_q;
    issue_d  = issue_q;
    accept_d = accept_q;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
    if (rd_en) issue_d = issue_q + 1'b1;
    if (pop)   accept_d = accept_q + 1'b1;
`ifdef WEIGHT_LOAD_EN
    ld_d      = ld_q;
    ld_done_d = 1'b0;
    ld_wr     = (state_q == S_LOAD) && LD_VALID;
`endif
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d  = S_RUN;
          issue_d  = '0;
          accept_d = '0;
        end
`ifdef WEIGHT_LOAD_EN
        else if (LD_START) begin
          state_d = S_LOAD;
          ld_d    = '0;
        end
`endif
      end
      S_RUN:     if (rd_en && (issue_q == LAST_IDX)) state_d = S_DRAIN;
      S_DRAIN:   if (pop && w_last) state_d = S_DONE_ST;
      S_DONE_ST: state_d = S_IDLE;
`ifdef WEIGHT_LOAD_EN
      S_LOAD: begin
        if (ld_wr) begin
          ld_d = ld_q + 1'b1;
          if (ld_q == LAST_IDX) begin
            state_d   = S_IDLE;
            ld_done_d = 1'b1;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      issue_q  <= '0;
      accept_q <= '0;
      buf0_q   <= '0;
      buf1_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
`ifdef WEIGHT_LOAD_EN
      ld_q      <= '0;
      ld_done_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      issue_q  <= issue_d;
      accept_q <= accept_d;
      count_q  <= count_d;
      if (push) begin
        if (wr_ptr_q) buf1_q <= BRAM_DO;
        else          buf0_q <= BRAM_DO;
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
`ifdef WEIGHT_LOAD_EN
      ld_q      <= ld_d;
      ld_done_q <= ld_done_d;
`endif
    end
  end

  assign BUSY    = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign DONE    = (state_q == S_DONE_ST);
  assign W_VALID = w_valid;
  assign W_LAST  = w_last;
  assign W_DATA  = w_valid ? head : '0;

`ifdef WEIGHT_LOAD_EN
  assign BRAM_EN   = rd_en || ld_wr;
  assign BRAM_WE   = ld_wr;
  assign BRAM_DI   = ld_wr ? LD_DATA : '0;
  assign BRAM_ADDR = rd_en ? issue_q[ADDR_W-1:0] : (ld_wr ? ld_q[ADDR_W-1:0] : '0);
  assign LD_DONE   = ld_done_q;
`else
  assign BRAM_EN   = rd_en;
  assign BRAM_WE   = 1'b0;
  assign BRAM_DI   = '0;
  assign BRAM_ADDR = rd_en ? issue_q[ADDR_W-1:0] : '0;
`endif

endmodule
